ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand/result width; legal values are even integers of 8 or more.
REQ-002 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising clk edge.
REQ-004 start_i  input  1  request for a new operation.
REQ-005 op_i  input  3  RV32M func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data_i / rs2_data_i  input  XLEN each  operands; rs1 is the multiplicand or dividend.
REQ-007 rd_addr_i  input  5  destination register, captured at start.
REQ-008 flush_i  input  1  abort the operation in flight, e.g. on a jump.
REQ-009 rd_data_o  output  XLEN  result.
REQ-010 rd_addr_o  output  5  captured destination register.
REQ-011 rd_wr_en  output  1  one-cycle register-file write strobe.
REQ-012 hold_flag_o  output  1  pipeline stall request.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE.
REQ-014 IDLE with start_i=1 and flush_i=0 SHALL latch op_i, rd_addr_i, operand magnitudes and sign flags, clear the iteration counter, and go to BUSY.
REQ-015 BUSY SHALL perform exactly one iteration per cycle:
  - multiply: shift-add, 1 bit per cycle;
  - divide: restoring, 1 quotient bit per cycle.
  After XLEN iterations it SHALL go to DONE.
REQ-016 DONE SHALL drive rd_wr_en=1, rd_data_o and rd_addr_o for exactly one cycle.
  - Next state is BUSY if start_i=1 and flush_i=0 (back-to-back accept, same latching as REQ-014).
  - Otherwise next state is IDLE.
REQ-017 Latency SHALL be fixed: start_i sampled at edge 0, rd_wr_en high in the cycle following edge XLEN (cycle XLEN+1), independent of operand values.
REQ-018 hold_flag_o SHALL be combinational and equal (IDLE & start_i & ~flush_i) | BUSY; it SHALL be 0 in DONE.
REQ-019 Outside DONE, rd_wr_en SHALL be 0 and rd_data_o and rd_addr_o SHALL be 0.
REQ-020 start_i while BUSY SHALL be ignored.
REQ-021 Multiply SHALL form a 2*XLEN-bit product of magnitudes and negate it when the operand signs differ.
  - Signedness: MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU and MUL unsigned.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
REQ-022 Division SHALL use magnitudes for DIV/REM; the quotient is negated when the signs differ, and the remainder takes the dividend's sign.
REQ-023 Divide by zero SHALL give: DIV/DIVU quotient all ones; REM/REMU remainder equal to rs1.
REQ-024 Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1) SHALL give DIV = rs1 and REM = 0.
REQ-025 Special-case results (REQ-023, REQ-024) SHALL still honour the latency in REQ-017.
REQ-026 flush_i=1 in BUSY or DONE SHALL force IDLE on the next edge.
  - In DONE, flush_i SHALL suppress rd_wr_en combinationally in the same cycle.
  - A start_i presented together with flush_i SHALL be dropped.
REQ-027 rd_wr_en SHALL assert even when rd_addr_o = 0; the register file discards writes to x0.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, zero the counter and all datapath registers, and discard any operation in flight with no write.
REQ-029 While rst is high, outputs SHALL be 0 from the next cycle: rd_data_o=0, rd_addr_o=0, rd_wr_en=0, hold_flag_o=0.
REQ-030 rst SHALL take priority over start_i and flush_i.

Verification (XLEN=32)
REQ-031 MUL 7 x 0xFFFFFFFD, start in cycle 0 -> hold_flag_o high in cycles 0-32; rd_wr_en pulses in cycle 33 with rd_data_o=0xFFFFFFEB.
REQ-032 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-033 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-034 Corner cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - All four complete at cycle 33.
REQ-035 Interruptions:
  - flush_i at cycle 10 -> no rd_wr_en; IDLE at cycle 11; a new start at cycle 11 completes at cycle 44.
  - rst at cycle 20 -> no write; outputs 0.
REQ-036 Back-to-back: second start_i held high during the DONE cycle of the first -> two rd_wr_en pulses 33 cycles apart with correct rd_addr_o on each.

Source files
------------

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
// One result bit per cycle; latency is fixed at XLEN+1 cycles from accept to write strobe.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wr_en,
  output logic            hold_flag_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic                neg_q, neg_d;
  logic                sa_q, sa_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                accept;
  logic                a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum, div_diff;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_mag, rem_mag, result;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && !flush_i) state_d = BUSY;
      BUSY:    if (flush_i) state_d = IDLE;
               else if (cnt_q == CW'(XLEN-1)) state_d = DONE;
      DONE:    state_d = (start_i && !flush_i) ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept  = start_i && !flush_i && (state_q == IDLE || state_q == DONE);
    a_sgn   = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    b_sgn   = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    a_neg   = a_sgn && rs1_data_i[XLEN-1];
    b_neg   = b_sgn && rs2_data_i[XLEN-1];
    a_mag   = a_neg ? -rs1_data_i : rs1_data_i;
    b_mag   = b_neg ? -rs2_data_i : rs2_data_i;
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    div_diff = prod_q[2*XLEN-1:XLEN-1] - {1'b0, a_q};

    op_d   = op_q;
    rd_d   = rd_q;
    a_d    = a_q;
    prod_d = prod_q;
    neg_d  = neg_q;
    sa_d   = sa_q;
    cnt_d  = cnt_q;

    if (accept) begin
      op_d  = op_i;
      rd_d  = rd_addr_i;
      sa_d  = a_neg;
      cnt_d = '0;
      if (op_i[2]) begin
        // Divide: a_q holds the divisor, prod_q is {remainder, quotient/dividend}.
        // A zero divisor must yield an all-ones quotient, so never negate it.
        a_d    = b_mag;
        prod_d = {{XLEN{1'b0}}, a_mag};
        neg_d  = (a_neg ^ b_neg) && (rs2_data_i != '0);
      end else begin
        a_d    = a_mag;
        prod_d = {{XLEN{1'b0}}, b_mag};
        neg_d  = a_neg ^ b_neg;
      end
    end else if (state_q == BUSY && !flush_i) begin
      cnt_d = cnt_q + CW'(1);
      if (op_q[2]) begin
        if (!div_diff[XLEN]) prod_d = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        else                 prod_d = {prod_q[2*XLEN-2:0], 1'b0};
      end else begin
        prod_d = {mul_sum, prod_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      rd_q   <= '0;
      a_q    <= '0;
      prod_q <= '0;
      neg_q  <= 1'b0;
      sa_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      op_q   <= op_d;
      rd_q   <= rd_d;
      a_q    <= a_d;
      prod_q <= prod_d;
      neg_q  <= neg_d;
      sa_q   <= sa_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    prod_s  = neg_q ? -prod_q : prod_q;
    quo_mag = prod_q[XLEN-1:0];
    rem_mag = prod_q[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      if (op_q[1]) result = sa_q  ? -rem_mag : rem_mag;
      else         result = neg_q ? -quo_mag : quo_mag;
    end else if (op_q[1:0] == 2'b00) begin
      result = prod_s[XLEN-1:0];
    end else begin
      result = prod_s[2*XLEN-1:XLEN];
    end

    hold_flag_o = !rst && ((state_q == IDLE && start_i && !flush_i) || state_q == BUSY);
    rd_wr_en    = !rst && !flush_i && (state_q == DONE);
    rd_data_o   = (state_q == DONE) ? result : '0;
    rd_addr_o   = (state_q == DONE) ? rd_q : 5'd0;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wr_en;
  logic        hold_flag_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
    .rd_wr_en(rd_wr_en), .hold_flag_o(hold_flag_o)
  );

  // Drives one operation from cycle 0 and waits (bounded) for its write strobe.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int cyc, output logic [31:0] data,
                       output logic [4:0] addr, output bit hold_ok);
    cyc = -1; data = '0; addr = '0; hold_ok = 1'b1;
    @(negedge clk);
    start_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    #1;
    if (hold_flag_o !== 1'b1) hold_ok = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      #1;
      if (rd_wr_en === 1'b1) begin
        cyc = i; data = rd_data_o; addr = rd_addr_o;
        if (hold_flag_o !== 1'b0) hold_ok = 1'b0;
        break;
      end
      if (hold_flag_o !== 1'b1) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b1; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rd_data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", rd_data_o); end
    checks++; if (rd_addr_o !== 5'h0) begin errors++; $display("FAIL reset_addr got %h want 0", rd_addr_o); end
    checks++; if (rd_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", rd_wr_en); end
    checks++; if (hold_flag_o !== 1'b0) begin errors++; $display("FAIL reset_hold got %b want 0", hold_flag_o); end
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
  endtask

  task automatic test_mul;
    int cyc; logic [31:0] d; logic [4:0] ad; bit h;
    do_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd3, cyc, d, ad, h);
    checks++; if (cyc != 33) begin errors++; $display("FAIL mul_latency got %0d want 33", cyc); end
    checks++; if (d !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_data got %h want ffffffeb", d); end
    checks++; if (ad !== 5'd3) begin errors++; $display("FAIL mul_addr got %0d want 3", ad); end
    checks++; if (!h) begin errors++; $display("FAIL mul_hold got 0 want 1 for cycles 0-32 and 0 in done"); end
    do_op(3'b001, 32'h80000000, 32'h80000000, 5'd4, cyc, d, ad, h);
    checks++; if (d !== 32'h40000000) begin errors++; $display("FAIL mulh_data got %h want 40000000", d); end
    do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, cyc, d, ad, h);
    checks++; if (d !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu_data got %h want fffffffe", d); end
    do_op(3'b010, 32'hFFFFFFFF, 32'd2, 5'd4, cyc, d, ad, h);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu_data got %h want ffffffff", d); end
  endtask

  task automatic test_div;
    int cyc; logic [31:0] d; logic [4:0] ad; bit h;
    do_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd8, cyc, d, ad, h);
    checks++; if (d !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_data got %h want fffffffd", d); end
    do_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd8, cyc, d, ad, h);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_data got %h want ffffffff", d); end
    do_op(3'b101, 32'd100, 32'd7, 5'd8, cyc, d, ad, h);
    checks++; if (d !== 32'd14) begin errors++; $display("FAIL divu_data got %h want 0000000e", d); end
    do_op(3'b111, 32'd100, 32'd7, 5'd8, cyc, d, ad, h);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL remu_data got %h want 00000002", d); end
    checks++; if (cyc != 33) begin errors++; $display("FAIL remu_latency got %0d want 33", cyc); end
  endtask

  task automatic test_corner;
    int cyc; logic [31:0] d; logic [4:0] ad; bit h;
    do_op(3'b101, 32'd5, 32'd0, 5'd0, cyc, d, ad, h);
    checks++; if (d !== 32'hFFFFFFFF || cyc != 33) begin errors++; $display("FAIL divu_by_zero got %h at %0d want ffffffff at 33", d, cyc); end
    checks++; if (ad !== 5'd0) begin errors++; $display("FAIL x0_addr got %0d want 0", ad); end
    do_op(3'b110, 32'd5, 32'd0, 5'd1, cyc, d, ad, h);
    checks++; if (d !== 32'd5 || cyc != 33) begin errors++; $display("FAIL rem_by_zero got %h at %0d want 00000005 at 33", d, cyc); end
    do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd2, cyc, d, ad, h);
    checks++; if (d !== 32'h80000000 || cyc != 33) begin errors++; $display("FAIL div_overflow got %h at %0d want 80000000 at 33", d, cyc); end
    do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd2, cyc, d, ad, h);
    checks++; if (d !== 32'h0 || cyc != 33) begin errors++; $display("FAIL rem_overflow got %h at %0d want 0 at 33", d, cyc); end
  endtask

  task automatic test_flush;
    int cyc; bit early_wr; logic [31:0] d; logic [4:0] ad;
    cyc = -1; early_wr = 1'b0; d = '0; ad = '0;
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b000; rs1_data_i = 32'd3; rs2_data_i = 32'd5; rd_addr_i = 5'd12;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (i == 10) flush_i = 1'b1;
      #1;
      if (rd_wr_en === 1'b1) early_wr = 1'b1;
    end
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b1; op_i = 3'b101; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_addr_i = 5'd7;
    #1;
    if (rd_wr_en === 1'b1) early_wr = 1'b1;
    for (int i = 12; i <= 70; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      #1;
      if (rd_wr_en === 1'b1) begin cyc = i; d = rd_data_o; ad = rd_addr_o; break; end
    end
    checks++; if (early_wr) begin errors++; $display("FAIL flush_no_write got write want none"); end
    checks++; if (cyc != 44) begin errors++; $display("FAIL flush_restart_latency got %0d want 44", cyc); end
    checks++; if (d !== 32'd14 || ad !== 5'd7) begin errors++; $display("FAIL flush_restart_result got %h/%0d want 0000000e/7", d, ad); end
  endtask

  task automatic test_flush_done;
    bit wr_seen;
    wr_seen = 1'b0;
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b000; rs1_data_i = 32'd2; rs2_data_i = 32'd2; rd_addr_i = 5'd6;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (i == 33) begin flush_i = 1'b1; start_i = 1'b1; end
      #1;
      if (rd_wr_en === 1'b1) wr_seen = 1'b1;
    end
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (rd_wr_en === 1'b1) wr_seen = 1'b1;
    end
    checks++; if (wr_seen) begin errors++; $display("FAIL flush_in_done got write want none"); end
  endtask

  task automatic test_rst_midop;
    bit wr_seen;
    wr_seen = 1'b0;
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b000; rs1_data_i = 32'd9; rs2_data_i = 32'd9; rd_addr_i = 5'd15;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (i == 20) rst = 1'b1;
    end
    @(negedge clk); #1;
    checks++; if ({rd_data_o, rd_addr_o, rd_wr_en, hold_flag_o} !== 39'h0) begin
      errors++; $display("FAIL rst_midop_outputs got %h/%0d/%b/%b want 0/0/0/0", rd_data_o, rd_addr_o, rd_wr_en, hold_flag_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (rd_wr_en === 1'b1) wr_seen = 1'b1;
    end
    checks++; if (wr_seen) begin errors++; $display("FAIL rst_midop_no_write got write want none"); end
  endtask

  task automatic test_back_to_back;
    int cyc2; logic [31:0] d1, d2; logic [4:0] a1, a2; logic w1, h1;
    cyc2 = -1; d2 = '0; a2 = '0;
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b000; rs1_data_i = 32'd6; rs2_data_i = 32'd7; rd_addr_i = 5'd5;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b101; rs1_data_i = 32'd1000; rs2_data_i = 32'd10; rd_addr_i = 5'd9;
    #1;
    w1 = rd_wr_en; d1 = rd_data_o; a1 = rd_addr_o; h1 = hold_flag_o;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start_i = (i == 5);
      if (i == 5) begin op_i = 3'b000; rs1_data_i = 32'd1; rs2_data_i = 32'd1; rd_addr_i = 5'd3; end
      #1;
      if (rd_wr_en === 1'b1) begin cyc2 = i; d2 = rd_data_o; a2 = rd_addr_o; break; end
    end
    checks++; if (w1 !== 1'b1 || d1 !== 32'd42 || a1 !== 5'd5) begin
      errors++; $display("FAIL b2b_first got wr=%b %h/%0d want wr=1 0000002a/5", w1, d1, a1);
    end
    checks++; if (h1 !== 1'b0) begin errors++; $display("FAIL b2b_done_hold got %b want 0", h1); end
    checks++; if (cyc2 != 33) begin errors++; $display("FAIL b2b_spacing got %0d want 33", cyc2); end
    checks++; if (d2 !== 32'd100 || a2 !== 5'd9) begin errors++; $display("FAIL b2b_second got %h/%0d want 00000064/9", d2, a2); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_corner();
    test_flush();
    test_flush_done();
    test_rst_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
